// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the RV32 pipeline.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 : the canonical bubble placed in IF/ID
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // FETCH: request outstanding; HOLD: word buffered while ID stalls;
  // DROP: waiting out a request made stale by a redirect
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  // Instructions are word aligned, so the low two address bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_skid_buf.sv
// One-entry {pc,inst} holding register used when a fetch completes while ID stalls.
module if_stage_skid_buf
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic            r_valid;

  // Capture on load; clear only drops the valid flag (load wins if both are seen).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 32'h0000_0000;
      r_inst  <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
  output logic            if_id_valid
);

  if_state_t       r_state;
  if_state_t       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_target_nxt;
  if_id_t          r_if_id;
  if_id_t          w_if_id_nxt;

  logic            w_req;
  logic            w_ack;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic [XLEN-1:0] w_buf_pc;
  logic [XLEN-1:0] w_buf_inst;
  logic            w_buf_valid;

  if_stage_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_inst  (imem_rdata),
    .o_pc    (w_buf_pc),
    .o_inst  (w_buf_inst),
    .o_valid (w_buf_valid)
  );

  // Request is live in FETCH and DROP; HOLD and reset never request.
  always_comb begin
    w_req = 1'b0;
    if (rst) begin
      w_req = 1'b0;
    end else begin
      case (r_state)
        FETCH:   w_req = 1'b1;
        DROP:    w_req = 1'b1;
        HOLD:    w_req = 1'b0;
        default: w_req = 1'b0;
      endcase
    end
  end

  // An ack is only meaningful while a request is outstanding.
  assign w_ack     = imem_ack & w_req;
  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  // Next-state logic; priority is redirect > stall > normal flow.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_target_nxt = r_target;
    w_if_id_nxt  = r_if_id;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_if_id_nxt.valid = 1'b0;
          w_if_id_nxt.inst  = NOP_INST;
          if (w_ack) begin
            w_pc_nxt = align_pc(redirect_pc);
          end else begin
            w_target_nxt = align_pc(redirect_pc);
            w_state_nxt  = DROP;
          end
        end else if (w_ack) begin
          w_pc_nxt = r_pc + 32'h0000_0004;
          if (stall) begin
            w_buf_load  = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_if_id_nxt.pc    = r_pc;
            w_if_id_nxt.inst  = imem_rdata;
            w_if_id_nxt.valid = 1'b1;
          end
        end else if (!stall) begin
          w_if_id_nxt.valid = 1'b0;
          w_if_id_nxt.inst  = NOP_INST;
        end else begin
          w_if_id_nxt = r_if_id;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_buf_clear       = 1'b1;
          w_pc_nxt          = align_pc(redirect_pc);
          w_state_nxt       = FETCH;
          w_if_id_nxt.valid = 1'b0;
          w_if_id_nxt.inst  = NOP_INST;
        end else if (!stall) begin
          // r_pc already points past the buffered word, so no refetch happens
          w_buf_clear       = 1'b1;
          w_if_id_nxt.pc    = w_buf_pc;
          w_if_id_nxt.inst  = w_buf_inst;
          w_if_id_nxt.valid = w_buf_valid;
          w_state_nxt       = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      DROP: begin
        // stall is irrelevant here: nothing real is in flight
        w_if_id_nxt.valid = 1'b0;
        w_if_id_nxt.inst  = NOP_INST;
        if (redirect) begin
          if (w_ack) begin
            w_pc_nxt    = align_pc(redirect_pc);
            w_state_nxt = FETCH;
          end else begin
            w_target_nxt = align_pc(redirect_pc);
          end
        end else if (w_ack) begin
          w_pc_nxt    = r_target;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: begin
        w_state_nxt       = FETCH;
        w_if_id_nxt.valid = 1'b0;
        w_if_id_nxt.inst  = NOP_INST;
      end
    endcase
  end

  // State, PC, redirect target and IF/ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_target      <= RESET_PC;
      r_if_id.pc    <= 32'h0000_0000;
      r_if_id.inst  <= NOP_INST;
      r_if_id.valid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
      r_if_id  <= w_if_id_nxt;
    end
  end

  assign if_id_pc    = r_if_id.pc;
  assign if_id_inst  = r_if_id.inst;
  assign if_id_valid = r_if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; the bench plays instruction memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  logic        ack_drv;
  logic        use_force;
  logic [31:0] force_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always #5 clk = ~clk;

  assign imem_ack   = ack_drv & imem_req;
  assign imem_rdata = use_force ? force_data : mem_word(imem_addr);

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ack_drv = 1'b0; stall = 1'b0; redirect = 1'b0; use_force = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
    n_tests++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL rst_inst got %h exp %h", if_id_inst, NOP); end
    n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", if_id_pc); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got %b exp 1", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rel_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    ack_drv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 32'(k * 4);
      tick();
      n_tests++; if (if_id_pc !== e) begin n_fail++; $display("FAIL zw_pc%0d got %h exp %h", k, if_id_pc, e); end
      n_tests++; if (if_id_inst !== mem_word(e)) begin n_fail++; $display("FAIL zw_inst%0d got %h exp %h", k, if_id_inst, mem_word(e)); end
      n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d got %b exp 1", k, if_id_valid); end
    end
    ack_drv = 1'b0;
  endtask

  task automatic test_stall_hold();
    ack_drv = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (if_id_pc !== 32'h4) begin n_fail++; $display("FAIL hold_pc%0d got %h exp 4", k, if_id_pc); end
      n_tests++; if (if_id_inst !== mem_word(32'h4)) begin n_fail++; $display("FAIL hold_inst%0d got %h exp %h", k, if_id_inst, mem_word(32'h4)); end
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req%0d got %b exp 0", k, imem_req); end
    end
    stall = 1'b0;
    tick();
    n_tests++; if (if_id_pc !== 32'h8) begin n_fail++; $display("FAIL rel_pc got %h exp 8", if_id_pc); end
    n_tests++; if (if_id_inst !== mem_word(32'h8)) begin n_fail++; $display("FAIL rel_inst got %h exp %h", if_id_inst, mem_word(32'h8)); end
    n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid got %b exp 1", if_id_valid); end
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req2 got %b exp 1", imem_req); end
    n_tests++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL rel_addr2 got %h exp c", imem_addr); end
    tick();
    n_tests++; if (if_id_pc !== 32'hC) begin n_fail++; $display("FAIL next_pc got %h exp c", if_id_pc); end
    ack_drv = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      e = 32'(k * 4);
      for (int w = 0; w < 2; w++) begin
        tick();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid%0d_%0d got %b exp 0", k, w, if_id_valid); end
        n_tests++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL ws_inst%0d_%0d got %h exp %h", k, w, if_id_inst, NOP); end
        n_tests++; if (imem_addr !== e) begin n_fail++; $display("FAIL ws_addr%0d_%0d got %h exp %h", k, w, imem_addr, e); end
      end
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      n_tests++; if (if_id_pc !== e) begin n_fail++; $display("FAIL ws_pc%0d got %h exp %h", k, if_id_pc, e); end
      n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ws_dvalid%0d got %b exp 1", k, if_id_valid); end
    end
  endtask

  task automatic test_redirect_drop();
    ack_drv = 1'b1;
    tick();
    tick();
    ack_drv = 1'b0;
    n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_pre_addr got %h exp 10", imem_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got %b exp 0", if_id_valid); end
    n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_old_addr got %h exp 10", imem_addr); end
    stall = 1'b1;
    tick();
    use_force = 1'b1;
    force_data = 32'hDEAD_BEEF;
    ack_drv = 1'b1;
    tick();
    use_force = 1'b0;
    stall = 1'b0;
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_discard got %b exp 0", if_id_valid); end
    n_tests++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL rd_inst got %h exp %h", if_id_inst, NOP); end
    n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_tgt_addr got %h exp 100", imem_addr); end
    tick();
    ack_drv = 1'b0;
    n_tests++; if (if_id_pc !== 32'h100) begin n_fail++; $display("FAIL rd_tgt_pc got %h exp 100", if_id_pc); end
    n_tests++; if (if_id_inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL rd_tgt_inst got %h exp %h", if_id_inst, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    ack_drv = 1'b1;
    tick();
    ack_drv = 1'b0;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rh_req got %b exp 0", imem_req); end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid got %b exp 0", if_id_valid); end
    n_tests++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL rh_inst got %h exp %h", if_id_inst, NOP); end
    n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rh_addr got %h exp 200", imem_addr); end
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rh_req2 got %b exp 1", imem_req); end
    ack_drv = 1'b1;
    tick();
    ack_drv = 1'b0;
    n_tests++; if (if_id_pc !== 32'h200) begin n_fail++; $display("FAIL rh_pc got %h exp 200", if_id_pc); end
  endtask

  task automatic test_async_reset_wrap();
    do_reset();
    ack_drv = 1'b1;
    repeat (8) tick();
    ack_drv = 1'b0;
    tick();
    n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL ar_addr got %h exp 20", imem_addr); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req got %b exp 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_pc got %h exp 0", imem_addr); end
    n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL ar_idpc got %h exp 0", if_id_pc); end
    n_tests++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL ar_inst got %h exp %h", if_id_inst, NOP); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_rel_req got %b exp 1", imem_req); end
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    ack_drv = 1'b1;
    tick();
    redirect = 1'b0;
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL wr_flush got %b exp 0", if_id_valid); end
    n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr got %h exp fffffffc", imem_addr); end
    tick();
    n_tests++; if (if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_pc got %h exp fffffffc", if_id_pc); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_wrap got %h exp 0", imem_addr); end
    tick();
    ack_drv = 1'b0;
    n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL wr_pc0 got %h exp 0", if_id_pc); end
    n_tests++; if (if_id_inst !== mem_word(32'h0)) begin n_fail++; $display("FAIL wr_inst0 got %h exp %h", if_id_inst, mem_word(32'h0)); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack_drv = 1'b0; use_force = 1'b0; force_data = 32'h0;
    test_reset();
    test_zero_wait();
    do_reset();
    test_stall_hold();
    do_reset();
    test_wait_states();
    test_redirect_drop();
    test_redirect_hold();
    test_async_reset_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
